// File: rtl/write_hit_check_ctrl.sv
// Write-hit check controller: looks up a request's index in an external tag RAM,
// compares tags, optionally allocates on miss, and returns hit/miss with a handshake.
//  state     | meaning
//  S_IDLE    | ready for a request
//  S_LOOKUP  | tag RAM read issued at captured index
//  S_COMPARE | RAM data valid, hit decided
//  S_UPDATE  | allocating miss: one-cycle tag write
//  S_RESP    | result held until resp_ready
module write_hit_check_ctrl #(
   parameter int AWIDTH = 3,
   parameter int DWIDTH = 14,
   localparam int RAW = AWIDTH + DWIDTH - 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [RAW-1:0]    req_addr,
   input  logic              req_alloc,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_hit,
   output logic [AWIDTH-1:0] resp_index,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_din,
   output logic              ram_we,
   input  logic [DWIDTH-1:0] ram_dout,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
);
   localparam int TW = DWIDTH - 1;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_COMPARE, S_UPDATE, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [TW-1:0]     tag_q, tag_d;
   logic [AWIDTH-1:0] idx_q, idx_d;
   logic              alloc_q, alloc_d;
   logic              hit_q, hit_d;
   logic [15:0]       hit_cnt_q, hit_cnt_d;
   logic [15:0]       miss_cnt_q, miss_cnt_d;
   logic              lookup_hit;

   assign lookup_hit = ram_dout[DWIDTH-1] && (ram_dout[DWIDTH-2:0] == tag_q);

   always_comb begin
      state_d    = state_q;
      tag_d      = tag_q;
      idx_d      = idx_q;
      alloc_d    = alloc_q;
      hit_d      = hit_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               tag_d   = req_addr[RAW-1:AWIDTH];
               idx_d   = req_addr[AWIDTH-1:0];
               alloc_d = req_alloc;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: state_d = S_COMPARE;
         S_COMPARE: begin
            hit_d = lookup_hit;
            if (lookup_hit) begin
               if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
               if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            end
            state_d = (!lookup_hit && alloc_q) ? S_UPDATE : S_RESP;
         end
         S_UPDATE: state_d = S_RESP;
         S_RESP: begin
            // Returning to IDLE first keeps a waiting request from being taken this edge.
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         tag_q      <= '0;
         idx_q      <= '0;
         alloc_q    <= 1'b0;
         hit_q      <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         tag_q      <= tag_d;
         idx_q      <= idx_d;
         alloc_q    <= alloc_d;
         hit_q      <= hit_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // Write strobe is decoded from state so reset drops it without waiting for a clock.
   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_hit   = hit_q;
   assign resp_index = idx_q;
   assign ram_addr   = idx_q;
   assign ram_we     = (state_q == S_UPDATE);
   assign ram_din    = (state_q == S_UPDATE) ? {1'b1, tag_q} : '0;
   assign hit_cnt    = hit_cnt_q;
   assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_write_hit_check_ctrl.sv
// Bench for write_hit_check_ctrl: behavioural tag-RAM model, directed cases then random requests.
module tb_write_hit_check_ctrl;
   localparam int AW = 3;
   localparam int DW = 14;
   localparam int RAW = AW + DW - 1;
   localparam int TW = DW - 1;

   logic           clock = 1'b0;
   logic           reset_n;
   logic           req_valid, req_ready, req_alloc;
   logic [RAW-1:0] req_addr;
   logic           resp_valid, resp_ready, resp_hit;
   logic [AW-1:0]  resp_index, ram_addr;
   logic [DW-1:0]  ram_din, ram_dout;
   logic           ram_we;
   logic [15:0]    hit_cnt, miss_cnt;

   always #5 clock = ~clock;

   write_hit_check_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_alloc(req_alloc),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_index(resp_index),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   // Synchronous tag RAM; index 2 preloaded valid with tag 0x0ABC.
   logic [DW-1:0] ram [8] = '{14'h0, 14'h0, 14'h2ABC, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0};
   always @(posedge clock) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
   end

   bit            m_valid [8];
   logic [TW-1:0] m_tag [8];
   int            exp_hits, exp_misses;
   int            n_checks, n_pass;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic do_req(input logic [TW-1:0] t, input logic [AW-1:0] i, input logic a,
                         input int delay, input bit overlap);
      bit            exp_hit, exp_alloc, addr_ok, stable;
      int            lat, we_cnt, waitc;
      logic [DW-1:0] din_seen;
      exp_hit   = m_valid[i] && (m_tag[i] == t);
      exp_alloc = !exp_hit && a;
      if (exp_hit) begin if (exp_hits < 65535) exp_hits++; end
      else begin if (exp_misses < 65535) exp_misses++; end
      if (exp_alloc) begin m_valid[i] = 1'b1; m_tag[i] = t; end

      waitc = 0;
      while (!req_ready && waitc < 20) begin @(posedge clock); #1; waitc++; end
      check_val("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_addr = {t, i}; req_alloc = a;
      @(posedge clock); #1;
      req_valid = 1'b0; req_addr = RAW'($urandom); req_alloc = 1'($urandom);

      lat = 0; we_cnt = 0; din_seen = '0; addr_ok = 1'b1;
      while (!resp_valid && lat < 10) begin
         if (ram_addr !== i) addr_ok = 1'b0;
         if (ram_we) begin we_cnt++; din_seen = ram_din; end
         @(posedge clock); #1; lat++;
      end
      check_val("latency", lat, exp_alloc ? 3 : 2);
      check_val("we_pulses", we_cnt, exp_alloc ? 1 : 0);
      if (exp_alloc) check_val("ram_din", din_seen, {1'b1, t});
      check_val("ram_addr_hold", addr_ok, 1);
      check_val("resp_hit", resp_hit, exp_hit);
      check_val("resp_index", resp_index, i);
      check_val("req_ready_busy", req_ready, 0);

      stable = 1'b1;
      repeat (delay) begin
         @(posedge clock); #1;
         if (!(resp_valid === 1'b1 && resp_hit === exp_hit && resp_index === i &&
               req_ready === 1'b0 && ram_we === 1'b0)) stable = 1'b0;
      end
      if (delay > 0) check_val("resp_stable", stable, 1);

      resp_ready = 1'b1;
      if (overlap) req_valid = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
      check_val("resp_done", resp_valid, 0);
      check_val("back_to_idle", req_ready, 1);
      check_val("hit_cnt", hit_cnt, exp_hits);
      check_val("miss_cnt", miss_cnt, exp_misses);
   endtask

   initial begin
      logic [DW-1:0] saved;
      logic [TW-1:0] t_miss;
      int            waitc;
      n_checks = 0; n_pass = 0; exp_hits = 0; exp_misses = 0;
      for (int k = 0; k < 8; k++) begin m_valid[k] = 1'b0; m_tag[k] = '0; end
      m_valid[2] = 1'b1; m_tag[2] = 13'h0ABC;
      reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_alloc = 1'b0; resp_ready = 1'b0;
      #3;
      check_val("rst_req_ready", req_ready, 1);
      check_val("rst_resp_valid", resp_valid, 0);
      check_val("rst_resp_hit", resp_hit, 0);
      check_val("rst_resp_index", resp_index, 0);
      check_val("rst_ram_we", ram_we, 0);
      check_val("rst_ram_addr", ram_addr, 0);
      check_val("rst_ram_din", ram_din, 0);
      check_val("rst_counters", {hit_cnt, miss_cnt}, 0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;

      do_req(13'h0ABC, 3'd2, 1'b0, 0, 1'b0);   // preloaded hit
      do_req(13'h0011, 3'd5, 1'b1, 0, 1'b0);   // allocating miss
      do_req(13'h0011, 3'd5, 1'b0, 0, 1'b0);   // now hits
      check_val("ram5", ram[5], 14'h2011);
      do_req(13'h0123, 3'd2, 1'b0, 0, 1'b0);   // mismatch, no alloc
      check_val("ram2_kept", ram[2], 14'h2ABC);
      do_req(13'h0ABC, 3'd2, 1'b0, 10, 1'b0);  // long backpressure
      do_req(13'h0042, 3'd1, 1'b0, 2, 1'b1);   // request waiting during RESP handshake
      do_req(13'h0042, 3'd1, 1'b1, 0, 1'b0);

      // Reset while in UPDATE: write must drop at once and the RAM must stay untouched.
      saved = ram[6];
      req_valid = 1'b1; req_addr = {13'h1555, 3'd6}; req_alloc = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      waitc = 0;
      while (!ram_we && waitc < 10) begin @(posedge clock); #1; waitc++; end
      check_val("upd_reached", ram_we, 1);
      #2 reset_n = 1'b0;
      #1;
      check_val("upd_rst_we", ram_we, 0);
      check_val("upd_rst_ready", req_ready, 0 + 1);
      check_val("upd_rst_resp", resp_valid, 0);
      check_val("upd_rst_cnt", {hit_cnt, miss_cnt}, 0);
      @(posedge clock); #3 reset_n = 1'b1;
      @(posedge clock); #1;
      check_val("upd_ram6", ram[6], saved);
      check_val("upd_no_resp", resp_valid, 0);
      exp_hits = 0; exp_misses = 0;

      for (int n = 0; n < 40; n++)
         do_req(TW'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), 1'($urandom),
                $urandom_range(0, 3), ($urandom_range(0, 3) == 0));

      // Miss counter saturation from a near-full value.
      force dut.miss_cnt_q = 16'hFFFE;
      @(posedge clock); #1;
      release dut.miss_cnt_q;
      exp_misses = 65534;
      t_miss = m_valid[0] ? m_tag[0] + 13'd1 : 13'd0;
      do_req(t_miss, 3'd0, 1'b0, 0, 1'b0);
      do_req(t_miss, 3'd0, 1'b0, 0, 1'b0);
      check_val("miss_sat", miss_cnt, 16'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
